wb_retire_unit: RTL and testbench
=================================

// Module: wb_retire_unit
// PURPOSE
//  Multi-lane writeback/retire stage for the rv32i pipeline; successor to the single-lane WB monitor tap.
//  Accepts up to LANES MEM/WB results per cycle and registers them (1-cycle latency).
//  Assigns contiguous 64-bit retire order, drives regfile write ports with same-cycle WAW suppression,
//  exposes per-lane RVFI monitor signals and runs a no-retire watchdog.
// PARAMETERS
//  LANES    2   retire lanes per cycle (1..4); lane 0 is oldest
//  TIMEOUT  4096  cycles without a retire before timeout asserts; 0 disables the watchdog
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          asynchronous active-low reset
//  wb_stall       in   1          downstream stall; holds off acceptance
//  in_valid       in   1          MEM/WB bundle valid
//  in_ready       out  1          = ~wb_stall (combinational)
//  in_commit      in   LANES      per-lane real instruction (0 = bubble)
//  in_inst/in_pc/in_pc_next            in  32*LANES  instruction, pc_rdata, pc_wdata
//  in_rs1_s/in_rs2_s/in_rd_s           in  5*LANES   register indices
//  in_rs1_v/in_rs2_v/in_rd_v           in  32*LANES  operand values, writeback data
//  in_mem_addr/in_mem_rdata/in_mem_wdata  in  32*LANES  data-memory access
//  in_mem_rmask/in_mem_wmask           in  4*LANES   byte masks
//  mon_valid      out  LANES      RVFI valid, one pulse per retired instruction
//  mon_order      out  64*LANES   RVFI order
//  mon_*          out  as in_*    registered copies of every in_* payload field above
//  rf_we          out  LANES      regfile write enable
//  rf_rd          out  5*LANES    regfile write index
//  rf_wdata       out  32*LANES   regfile write data
//  timeout        out  1          watchdog expired
// BEHAVIOUR
//  - Reset (rst_n low, asynchronous): mon_valid=0, rf_we=0, all mon_*/rf_* data=0, order_q=0, wdog=0, timeout=0.
//  - Accept = in_valid & ~wb_stall. On accept, stage register loads all lanes at the next edge.
//    mon_valid[i] = in_commit[i]. Otherwise mon_valid = 0 next cycle.
//    Payload holds its last value; no instruction ever retires twice.
//  - Order: lane i gets order_q + popcount(in_commit[i-1:0]); order_q += popcount(in_commit) on accept.
//    Bubble lanes consume no order; non-contiguous commit masks are legal. order_q wraps mod 2^64.
//  - Regfile: rf_we[i] = mon_valid[i] & (mon_rd_s[i] != 0) & ~(any j>i with mon_valid[j] and mon_rd_s[j]==mon_rd_s[i]).
//    The youngest writer wins. rf_rd/rf_wdata = mon_rd_s/mon_rd_v.
//    mon_rd_v is reported unmodified even when rf_we is suppressed.
//  - Watchdog: a cycle counts as "any retire" when |mon_valid.
//    Any retire: wdog=0 and timeout=0.
//    Otherwise wdog increments, saturating at TIMEOUT; timeout=1 when wdog==TIMEOUT. timeout is sticky until the next retire.
//    TIMEOUT=0: timeout stays 0.
//  - Stall with in_valid high: nothing accepted, mon_valid=0 and order_q unchanged; the watchdog still counts.
//  - Reset mid-stream: in-flight stage contents are discarded; the first post-reset retire has order 0.
// CONFIGURATION
//  WB_FWD_EN defined: adds outputs fwd_valid[LANES], fwd_rd[5*LANES], fwd_data[32*LANES].
//    fwd_valid = rf_we; fwd_rd = rf_rd; fwd_data = rf_wdata, for WB->EX bypass. Reset value 0.
//  WB_FWD_EN undefined: the ports do not exist and no forwarding logic is built; all other behaviour is identical.
// TESTING
//  - Reset, then LANES=2, in_commit=2'b11, rd=x5/x6 -> next cycle mon_valid=11, orders 0/1, rf_we=11; following accept starts at order 2.
//  - in_commit=2'b10 -> only lane1 valid, order = order_q; order_q advances by 1; lane0 rf_we=0.
//  - Both lanes rd=x7 with data 0xAAAA/0x5555 -> rf_we=2'b10, rf_wdata[1]=0x5555; both mon_valid=1.
//  - Lane rd=x0 with commit=1 -> mon_valid=1, rf_we=0.
//  - wb_stall=1 for 3 cycles with in_valid=1 -> in_ready=0, mon_valid=0, order_q unchanged; release -> single retire.
//  - TIMEOUT=8, no commits -> timeout rises on cycle 8 after the last retire and stays high; the next retire clears it.
//  - Assert rst_n low mid-stream -> outputs 0 immediately (asynchronous); first retire afterwards has order 0.
//  - WB_FWD_EN builds: fwd_* equal rf_* every cycle.

Source files
------------

// File: rtl/wb_retire_unit.sv
// Multi-lane writeback/retire stage: registers MEM/WB bundles, assigns retire order,
// drives regfile writes with youngest-wins WAW suppression, and runs a no-retire watchdog.
// Optional macro WB_FWD_EN adds fwd_valid/fwd_rd/fwd_data bypass outputs.
module wb_retire_unit #(
    parameter int unsigned LANES   = 2,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_stall,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_commit,
    input  logic [32*LANES-1:0]   in_inst,
    input  logic [32*LANES-1:0]   in_pc,
    input  logic [32*LANES-1:0]   in_pc_next,
    input  logic [5*LANES-1:0]    in_rs1_s,
    input  logic [5*LANES-1:0]    in_rs2_s,
    input  logic [5*LANES-1:0]    in_rd_s,
    input  logic [32*LANES-1:0]   in_rs1_v,
    input  logic [32*LANES-1:0]   in_rs2_v,
    input  logic [32*LANES-1:0]   in_rd_v,
    input  logic [32*LANES-1:0]   in_mem_addr,
    input  logic [32*LANES-1:0]   in_mem_rdata,
    input  logic [32*LANES-1:0]   in_mem_wdata,
    input  logic [4*LANES-1:0]    in_mem_rmask,
    input  logic [4*LANES-1:0]    in_mem_wmask,
    output logic [LANES-1:0]      mon_valid,
    output logic [64*LANES-1:0]   mon_order,
    output logic [32*LANES-1:0]   mon_inst,
    output logic [32*LANES-1:0]   mon_pc,
    output logic [32*LANES-1:0]   mon_pc_next,
    output logic [5*LANES-1:0]    mon_rs1_s,
    output logic [5*LANES-1:0]    mon_rs2_s,
    output logic [5*LANES-1:0]    mon_rd_s,
    output logic [32*LANES-1:0]   mon_rs1_v,
    output logic [32*LANES-1:0]   mon_rs2_v,
    output logic [32*LANES-1:0]   mon_rd_v,
    output logic [32*LANES-1:0]   mon_mem_addr,
    output logic [32*LANES-1:0]   mon_mem_rdata,
    output logic [32*LANES-1:0]   mon_mem_wdata,
    output logic [4*LANES-1:0]    mon_mem_rmask,
    output logic [4*LANES-1:0]    mon_mem_wmask,
    output logic [LANES-1:0]      rf_we,
    output logic [5*LANES-1:0]    rf_rd,
    output logic [32*LANES-1:0]   rf_wdata,
    output logic                  timeout
`ifdef WB_FWD_EN
    ,
    output logic [LANES-1:0]      fwd_valid,
    output logic [5*LANES-1:0]    fwd_rd,
    output logic [32*LANES-1:0]   fwd_data
`endif
);

    localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WMAX = WW'(TIMEOUT);

    logic                accept;
    logic [63:0]         order_q;
    logic [63:0]         order_sum;
    logic [64*LANES-1:0] next_order;
    logic [WW-1:0]       wdog;

    assign in_ready = ~wb_stall;
    assign accept   = in_valid & ~wb_stall;

    // Bubble lanes take the order the next real instruction would get but consume none.
    always_comb begin
        order_sum  = order_q;
        next_order = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            next_order[64*i +: 64] = order_sum;
            order_sum = order_sum + 64'(in_commit[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_valid     <= '0;
            mon_order     <= '0;
            mon_inst      <= '0;
            mon_pc        <= '0;
            mon_pc_next   <= '0;
            mon_rs1_s     <= '0;
            mon_rs2_s     <= '0;
            mon_rd_s      <= '0;
            mon_rs1_v     <= '0;
            mon_rs2_v     <= '0;
            mon_rd_v      <= '0;
            mon_mem_addr  <= '0;
            mon_mem_rdata <= '0;
            mon_mem_wdata <= '0;
            mon_mem_rmask <= '0;
            mon_mem_wmask <= '0;
            order_q       <= '0;
        end else if (accept) begin
            mon_valid     <= in_commit;
            mon_order     <= next_order;
            mon_inst      <= in_inst;
            mon_pc        <= in_pc;
            mon_pc_next   <= in_pc_next;
            mon_rs1_s     <= in_rs1_s;
            mon_rs2_s     <= in_rs2_s;
            mon_rd_s      <= in_rd_s;
            mon_rs1_v     <= in_rs1_v;
            mon_rs2_v     <= in_rs2_v;
            mon_rd_v      <= in_rd_v;
            mon_mem_addr  <= in_mem_addr;
            mon_mem_rdata <= in_mem_rdata;
            mon_mem_wdata <= in_mem_wdata;
            mon_mem_rmask <= in_mem_rmask;
            mon_mem_wmask <= in_mem_wmask;
            order_q       <= order_sum;
        end else begin
            mon_valid     <= '0;
        end
    end

    // A lane loses its write if any younger valid lane targets the same register.
    always_comb begin
        rf_we = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            rf_we[i] = mon_valid[i] && (mon_rd_s[5*i +: 5] != 5'd0);
            for (int unsigned j = 0; j < LANES; j++) begin
                if (j > i && mon_valid[j] && (mon_rd_s[5*j +: 5] == mon_rd_s[5*i +: 5]))
                    rf_we[i] = 1'b0;
            end
        end
    end

    assign rf_rd    = mon_rd_s;
    assign rf_wdata = mon_rd_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog    <= '0;
            timeout <= 1'b0;
        end else if (|mon_valid) begin
            wdog    <= '0;
            timeout <= 1'b0;
        end else if (TIMEOUT != 0) begin
            if (wdog != WMAX) begin
                wdog    <= wdog + 1'b1;
                timeout <= (wdog == WMAX - 1'b1);
            end
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid = rf_we;
    assign fwd_rd    = rf_rd;
    assign fwd_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_retire_unit.sv
// Randomized bench for wb_retire_unit: a retired-count / youngest-writer model checked
// every cycle, plus directed literal checks for ordering, WAW, stall, watchdog and reset.
module tb_wb_retire_unit;

    localparam int unsigned LANES = 2;
    localparam int unsigned TMO   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wb_stall = 1'b0, in_valid = 1'b0, in_ready;
    logic [LANES-1:0]    in_commit = '0;
    logic [32*LANES-1:0] in_inst = '0, in_pc = '0, in_pc_next = '0;
    logic [5*LANES-1:0]  in_rs1_s = '0, in_rs2_s = '0, in_rd_s = '0;
    logic [32*LANES-1:0] in_rs1_v = '0, in_rs2_v = '0, in_rd_v = '0;
    logic [32*LANES-1:0] in_mem_addr = '0, in_mem_rdata = '0, in_mem_wdata = '0;
    logic [4*LANES-1:0]  in_mem_rmask = '0, in_mem_wmask = '0;
    logic [LANES-1:0]    mon_valid, rf_we;
    logic [64*LANES-1:0] mon_order;
    logic [32*LANES-1:0] mon_inst, mon_pc, mon_pc_next, mon_rs1_v, mon_rs2_v, mon_rd_v;
    logic [32*LANES-1:0] mon_mem_addr, mon_mem_rdata, mon_mem_wdata, rf_wdata;
    logic [5*LANES-1:0]  mon_rs1_s, mon_rs2_s, mon_rd_s, rf_rd;
    logic [4*LANES-1:0]  mon_mem_rmask, mon_mem_wmask;
    logic                timeout;
`ifdef WB_FWD_EN
    logic [LANES-1:0]    fwd_valid;
    logic [5*LANES-1:0]  fwd_rd;
    logic [32*LANES-1:0] fwd_data;
`endif

    wb_retire_unit #(.LANES(LANES), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall), .in_valid(in_valid), .in_ready(in_ready),
        .in_commit(in_commit), .in_inst(in_inst), .in_pc(in_pc), .in_pc_next(in_pc_next),
        .in_rs1_s(in_rs1_s), .in_rs2_s(in_rs2_s), .in_rd_s(in_rd_s),
        .in_rs1_v(in_rs1_v), .in_rs2_v(in_rs2_v), .in_rd_v(in_rd_v),
        .in_mem_addr(in_mem_addr), .in_mem_rdata(in_mem_rdata), .in_mem_wdata(in_mem_wdata),
        .in_mem_rmask(in_mem_rmask), .in_mem_wmask(in_mem_wmask),
        .mon_valid(mon_valid), .mon_order(mon_order), .mon_inst(mon_inst), .mon_pc(mon_pc),
        .mon_pc_next(mon_pc_next), .mon_rs1_s(mon_rs1_s), .mon_rs2_s(mon_rs2_s), .mon_rd_s(mon_rd_s),
        .mon_rs1_v(mon_rs1_v), .mon_rs2_v(mon_rs2_v), .mon_rd_v(mon_rd_v),
        .mon_mem_addr(mon_mem_addr), .mon_mem_rdata(mon_mem_rdata), .mon_mem_wdata(mon_mem_wdata),
        .mon_mem_rmask(mon_mem_rmask), .mon_mem_wmask(mon_mem_wmask),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .timeout(timeout)
`ifdef WB_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model state: what the retire stage must present after each edge.
    logic [LANES-1:0]    e_valid = '0;
    logic [64*LANES-1:0] e_order = '0;
    logic [32*LANES-1:0] e_inst = '0, e_pc = '0, e_pcn = '0, e_rs1v = '0, e_rs2v = '0, e_rdv = '0;
    logic [32*LANES-1:0] e_maddr = '0, e_mrd = '0, e_mwd = '0;
    logic [5*LANES-1:0]  e_rs1s = '0, e_rs2s = '0, e_rds = '0;
    logic [4*LANES-1:0]  e_rmask = '0, e_wmask = '0;
    logic [63:0]         retired = '0;
    int unsigned         idle_cnt = 0;

    initial begin
        logic [LANES-1:0] e_we;
        int win [32];
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                e_valid = '0; e_order = '0; e_inst = '0; e_pc = '0; e_pcn = '0;
                e_rs1s = '0; e_rs2s = '0; e_rds = '0; e_rs1v = '0; e_rs2v = '0; e_rdv = '0;
                e_maddr = '0; e_mrd = '0; e_mwd = '0; e_rmask = '0; e_wmask = '0;
                retired = '0; idle_cnt = 0;
            end else begin
                if (|e_valid) idle_cnt = 0;
                else if (idle_cnt < TMO) idle_cnt++;
                if (in_valid && !wb_stall) begin
                    for (int i = 0; i < LANES; i++) begin
                        e_order[64*i +: 64] = retired;
                        if (in_commit[i]) retired = retired + 64'd1;
                    end
                    e_valid = in_commit; e_inst = in_inst; e_pc = in_pc; e_pcn = in_pc_next;
                    e_rs1s = in_rs1_s; e_rs2s = in_rs2_s; e_rds = in_rd_s;
                    e_rs1v = in_rs1_v; e_rs2v = in_rs2_v; e_rdv = in_rd_v;
                    e_maddr = in_mem_addr; e_mrd = in_mem_rdata; e_mwd = in_mem_wdata;
                    e_rmask = in_mem_rmask; e_wmask = in_mem_wmask;
                end else begin
                    e_valid = '0;
                end
            end
            for (int r = 0; r < 32; r++) win[r] = -1;
            for (int i = 0; i < LANES; i++)
                if (e_valid[i]) win[e_rds[5*i +: 5]] = i;
            for (int i = 0; i < LANES; i++)
                e_we[i] = e_valid[i] && (e_rds[5*i +: 5] != 5'd0) && (win[e_rds[5*i +: 5]] == i);
            #1;
            chk("in_ready", 256'(in_ready), 256'(!wb_stall));
            chk("mon_valid", 256'(mon_valid), 256'(e_valid));
            chk("mon_order", 256'(mon_order), 256'(e_order));
            chk("mon_inst", 256'(mon_inst), 256'(e_inst));
            chk("mon_pc", 256'({mon_pc, mon_pc_next}), 256'({e_pc, e_pcn}));
            chk("mon_regs", 256'({mon_rs1_s, mon_rs2_s, mon_rd_s}), 256'({e_rs1s, e_rs2s, e_rds}));
            chk("mon_vals", 256'({mon_rs1_v, mon_rs2_v, mon_rd_v}), 256'({e_rs1v, e_rs2v, e_rdv}));
            chk("mon_mem", 256'({mon_mem_addr, mon_mem_rdata, mon_mem_wdata}), 256'({e_maddr, e_mrd, e_mwd}));
            chk("mon_mask", 256'({mon_mem_rmask, mon_mem_wmask}), 256'({e_rmask, e_wmask}));
            chk("rf_we", 256'(rf_we), 256'(e_we));
            chk("rf_rd", 256'(rf_rd), 256'(e_rds));
            chk("rf_wdata", 256'(rf_wdata), 256'(e_rdv));
            chk("timeout", 256'(timeout), 256'(idle_cnt >= TMO));
`ifdef WB_FWD_EN
            chk("fwd", 256'({fwd_valid, fwd_rd, fwd_data}), 256'({rf_we, rf_rd, rf_wdata}));
`endif
        end
    end

    task automatic set_in(input logic v, input logic st, input logic [LANES-1:0] c);
        @(negedge clk);
        in_valid = v; wb_stall = st; in_commit = c;
        for (int i = 0; i < LANES; i++) begin
            in_inst[32*i +: 32] = $urandom();      in_pc[32*i +: 32] = $urandom();
            in_pc_next[32*i +: 32] = $urandom();   in_rs1_v[32*i +: 32] = $urandom();
            in_rs2_v[32*i +: 32] = $urandom();     in_rd_v[32*i +: 32] = $urandom();
            in_mem_addr[32*i +: 32] = $urandom();  in_mem_rdata[32*i +: 32] = $urandom();
            in_mem_wdata[32*i +: 32] = $urandom();
            in_rs1_s[5*i +: 5] = 5'($urandom());   in_rs2_s[5*i +: 5] = 5'($urandom());
            in_rd_s[5*i +: 5] = 5'($urandom_range(0, 3));
            in_mem_rmask[4*i +: 4] = 4'($urandom()); in_mem_wmask[4*i +: 4] = 4'($urandom());
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #2;
    endtask

    task automatic random_run(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, LANES'($urandom()));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("lit_reset_valid", 256'(mon_valid), 256'(0));
        chk("lit_reset_order", 256'(mon_order), 256'(0));
        chk("lit_reset_timeout", 256'(timeout), 256'(0));
        @(negedge clk) rst_n = 1'b1;

        set_in(1'b1, 1'b0, 2'b11);
        in_rd_s = {5'd6, 5'd5};
        edge_wait();
        chk("lit_pair_valid", 256'(mon_valid), 256'(2'b11));
        chk("lit_pair_order", 256'(mon_order), 256'({64'd1, 64'd0}));
        chk("lit_pair_we", 256'(rf_we), 256'(2'b11));

        set_in(1'b1, 1'b0, 2'b10);
        in_rd_s = {5'd9, 5'd9};
        edge_wait();
        chk("lit_hole_valid", 256'(mon_valid), 256'(2'b10));
        chk("lit_hole_order1", 256'(mon_order[127:64]), 256'(2));
        chk("lit_hole_we", 256'(rf_we), 256'(2'b10));

        set_in(1'b1, 1'b0, 2'b11);
        in_rd_s = {5'd7, 5'd7};
        in_rd_v = {32'h5555, 32'hAAAA};
        edge_wait();
        chk("lit_waw_we", 256'(rf_we), 256'(2'b10));
        chk("lit_waw_data1", 256'(rf_wdata[63:32]), 256'(32'h5555));
        chk("lit_waw_data0", 256'(mon_rd_v[31:0]), 256'(32'hAAAA));
        chk("lit_waw_order", 256'(mon_order), 256'({64'd4, 64'd3}));

        set_in(1'b1, 1'b0, 2'b01);
        in_rd_s = {5'd3, 5'd0};
        edge_wait();
        chk("lit_x0_valid", 256'(mon_valid), 256'(2'b01));
        chk("lit_x0_we", 256'(rf_we), 256'(0));

        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 1'b1, 2'b11);
            #1 chk("lit_stall_ready", 256'(in_ready), 256'(0));
            edge_wait();
            chk("lit_stall_valid", 256'(mon_valid), 256'(0));
        end
        set_in(1'b1, 1'b0, 2'b01);
        edge_wait();
        chk("lit_release_order", 256'({mon_valid, mon_order[63:0]}), 256'({2'b01, 64'd6}));

        for (int k = 1; k <= 12; k++) begin
            set_in(1'b0, 1'b0, 2'b00);
            edge_wait();
            if (k == 8) chk("lit_tmo_before", 256'(timeout), 256'(0));
            if (k == 9 || k == 12) chk("lit_tmo_high", 256'(timeout), 256'(1));
        end
        set_in(1'b1, 1'b0, 2'b10);
        edge_wait();
        set_in(1'b0, 1'b0, 2'b00);
        edge_wait();
        chk("lit_tmo_cleared", 256'(timeout), 256'(0));

        random_run(400);

        set_in(1'b1, 1'b0, 2'b11);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("lit_async_valid", 256'(mon_valid), 256'(0));
        chk("lit_async_data", 256'({mon_order, rf_wdata, rf_we}), 256'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        set_in(1'b1, 1'b0, 2'b11);
        edge_wait();
        chk("lit_post_reset_order", 256'(mon_order), 256'({64'd1, 64'd0}));

        random_run(400);
        set_in(1'b0, 1'b0, 2'b00);
        edge_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
